// File: rtl/audio_sched_pkg.sv
// Shared definitions for the audio-out scheduler and its round-robin picker.
//   - sched_state_t : scheduler FSM state encoding
//   - MODE_RR/MODE_MIX : values of the mix_mode input
//   - IDX_W : width of source indices and of the round-robin pointer
//   - MIX_GUARD : headroom bits added to the sample width when summing sources
//   - sat_hi/sat_lo : clamp limits for a DW-bit two's-complement sample,
//                     expressed at the widened DW+MIX_GUARD summing width
package audio_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WRITE = 2'd2
    } sched_state_t;

    localparam logic MODE_RR  = 1'b0;
    localparam logic MODE_MIX = 1'b1;

    // Up to 8 sources, so a 3-bit index covers every source number.
    localparam int IDX_W = 3;

    // 8 sources * full-scale samples need at most 3 extra bits before clamping.
    localparam int MIX_GUARD = 3;

    // Most positive DW-bit sample, widened to DW+MIX_GUARD bits.
    function automatic logic [63:0] sat_hi(input int dw);
        logic [63:0] v;
        v = (64'd1 << (dw - 1)) - 64'd1;
        return v;
    endfunction

    // Most negative DW-bit sample, sign-extended to 64 bits; callers truncate.
    function automatic logic [63:0] sat_lo(input int dw);
        logic [63:0] v;
        v = ~((64'd1 << (dw - 1)) - 64'd1);
        return v;
    endfunction

endpackage

// File: rtl/audio_out_scheduler_if.sv
// Bus between the tone sources / Audio_Controller and the scheduler.
//   src_valid/src_ready         : per-source handshake
//   src_left/src_right          : packed sample pairs, source i at [i*DW +: DW]
//   audio_out_allowed           : Audio_Controller output FIFO has room
//   write_audio_out             : one-cycle write strobe to Audio_Controller
//   left/right_channel_audio_out: sample pair presented with the strobe
// The scheduler uses the slave modport; the environment uses master.
interface audio_out_scheduler_if #(
    parameter int N_SRC = 4,
    parameter int DW    = 32
);
    logic [N_SRC-1:0]    src_valid;
    logic [N_SRC-1:0]    src_ready;
    logic [N_SRC*DW-1:0] src_left;
    logic [N_SRC*DW-1:0] src_right;
    logic                audio_out_allowed;
    logic                write_audio_out;
    logic [DW-1:0]       left_channel_audio_out;
    logic [DW-1:0]       right_channel_audio_out;

    modport slave (
        input  src_valid, src_left, src_right, audio_out_allowed,
        output src_ready, write_audio_out,
               left_channel_audio_out, right_channel_audio_out
    );

    modport master (
        output src_valid, src_left, src_right, audio_out_allowed,
        input  src_ready, write_audio_out,
               left_channel_audio_out, right_channel_audio_out
    );
endinterface

// File: rtl/audio_out_scheduler_rr_pick.sv
// rr_pick: combinational round-robin priority encoder.
//   valid  : request vector, one bit per source
//   ptr    : highest-priority index (must be < N_SRC)
//   winner : first requesting index at or after ptr, wrapping modulo N_SRC
//   found  : at least one request present
// The wrap is explicit, so N_SRC need not be a power of two.
import audio_sched_pkg::*;

module rr_pick #(
    parameter int N_SRC = 4
) (
    input  logic [N_SRC-1:0] valid,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] winner,
    output logic             found
);

    logic [IDX_W-1:0] cand_idx [N_SRC];
    logic [N_SRC-1:0] cand_hit;

    // Candidate gi is the source gi places after the pointer.
    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_cand
            logic [IDX_W:0] raw_idx;
            assign raw_idx = {1'b0, ptr} + (IDX_W+1)'(gi);
            assign cand_idx[gi] = (raw_idx >= (IDX_W+1)'(N_SRC))
                                ? IDX_W'(raw_idx - (IDX_W+1)'(N_SRC))
                                : raw_idx[IDX_W-1:0];
            assign cand_hit[gi] = |(valid & (N_SRC'(1) << cand_idx[gi]));
        end
    endgenerate

    // Scan from the farthest candidate down so the nearest one wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (cand_hit[i]) begin
                winner = cand_idx[i];
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/audio_out_scheduler.sv
// audio_out_scheduler: shares the Audio_Controller write port among N_SRC
// sample sources. In LOAD it accepts either one source (round-robin) or all
// pending sources (saturating sum), latches the resulting pair, then in WRITE
// strobes write_audio_out for one cycle as soon as audio_out_allowed is high.
// Ports:
//   CLOCK_50  : clock, rising edge
//   reset_n   : asynchronous active-low reset
//   bus       : source handshake + Audio_Controller write side (slave modport)
//   mix_mode  : 0 = round-robin exclusive, 1 = saturating mix (sampled in LOAD)
//   mute      : write zeros while still consuming sources (sampled in LOAD)
//   grant_idx : last source granted in round-robin mode
//   busy      : FSM not in IDLE
import audio_sched_pkg::*;

module audio_out_scheduler #(
    parameter int N_SRC = 4,
    parameter int DW    = 32
) (
    input  logic                  CLOCK_50,
    input  logic                  reset_n,
    audio_out_scheduler_if.slave  bus,
    input  logic                  mix_mode,
    input  logic                  mute,
    output logic [2:0]            grant_idx,
    output logic                  busy
);

    localparam int SW = DW + MIX_GUARD;
    localparam logic signed [SW-1:0] SAT_HI = SW'(sat_hi(DW));
    localparam logic signed [SW-1:0] SAT_LO = SW'(sat_lo(DW));

    sched_state_t     state_reg, state_next;
    logic [IDX_W-1:0] ptr_reg;
    logic [IDX_W-1:0] grant_reg;
    logic [DW-1:0]    left_reg, right_reg;

    logic [N_SRC-1:0] ready_next;
    logic             write_next;
    logic             load_en;

    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;
    logic [IDX_W-1:0] ptr_after_pick;

    logic [DW-1:0]        left_arr  [N_SRC];
    logic [DW-1:0]        right_arr [N_SRC];
    logic signed [SW-1:0] left_ext  [N_SRC];
    logic signed [SW-1:0] right_ext [N_SRC];
    logic signed [SW-1:0] left_sum, right_sum;
    logic [DW-1:0]        rr_left, rr_right;
    logic [N_SRC-1:0]     rr_onehot;

    rr_pick #(.N_SRC(N_SRC)) u_rr_pick (
        .valid  (bus.src_valid),
        .ptr    (ptr_reg),
        .winner (pick_idx),
        .found  (pick_found)
    );

    // Unpack per-source samples; invalid sources contribute zero to the sum.
    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
            assign left_arr[gi]  = bus.src_left [gi*DW +: DW];
            assign right_arr[gi] = bus.src_right[gi*DW +: DW];
            assign left_ext[gi]  = bus.src_valid[gi]
                                 ? {{MIX_GUARD{left_arr[gi][DW-1]}}, left_arr[gi]}
                                 : '0;
            assign right_ext[gi] = bus.src_valid[gi]
                                 ? {{MIX_GUARD{right_arr[gi][DW-1]}}, right_arr[gi]}
                                 : '0;
            assign rr_onehot[gi] = (IDX_W'(gi) == pick_idx);
        end
    endgenerate

    always_comb begin
        left_sum  = '0;
        right_sum = '0;
        rr_left   = '0;
        rr_right  = '0;
        for (int i = 0; i < N_SRC; i++) begin
            left_sum  = left_sum  + left_ext[i];
            right_sum = right_sum + right_ext[i];
            if (rr_onehot[i]) begin
                rr_left  = left_arr[i];
                rr_right = right_arr[i];
            end
        end
    end

    assign ptr_after_pick = (pick_idx == IDX_W'(N_SRC - 1)) ? '0 : pick_idx + 1'b1;

    function automatic logic [DW-1:0] saturate(input logic signed [SW-1:0] v);
        if (v > SAT_HI)
            return SAT_HI[DW-1:0];
        else if (v < SAT_LO)
            return SAT_LO[DW-1:0];
        else
            return v[DW-1:0];
    endfunction

    // FSM state register
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    // FSM next state and handshake outputs
    always_comb begin
        state_next = state_reg;
        ready_next = '0;
        write_next = 1'b0;
        load_en    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (|bus.src_valid)
                    state_next = ST_LOAD;
            end
            ST_LOAD: begin
                // A source that withdrew after IDLE saw it gets no ack.
                if (pick_found) begin
                    load_en    = 1'b1;
                    ready_next = (mix_mode == MODE_MIX) ? bus.src_valid : rr_onehot;
                    state_next = ST_WRITE;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_WRITE: begin
                write_next = bus.audio_out_allowed;
                if (bus.audio_out_allowed)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output sample, grant and pointer registers; only LOAD updates them.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            left_reg  <= '0;
            right_reg <= '0;
            grant_reg <= '0;
            ptr_reg   <= '0;
        end else if (load_en) begin
            if (mute) begin
                left_reg  <= '0;
                right_reg <= '0;
            end else if (mix_mode == MODE_MIX) begin
                left_reg  <= saturate(left_sum);
                right_reg <= saturate(right_sum);
            end else begin
                left_reg  <= rr_left;
                right_reg <= rr_right;
            end
            if (mix_mode != MODE_MIX) begin
                grant_reg <= pick_idx;
                ptr_reg   <= ptr_after_pick;
            end
        end
    end

    assign bus.src_ready               = ready_next;
    assign bus.write_audio_out         = write_next;
    assign bus.left_channel_audio_out  = left_reg;
    assign bus.right_channel_audio_out = right_reg;
    assign grant_idx                   = grant_reg;
    assign busy                        = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_audio_out_scheduler.sv
// Self-checking bench for audio_out_scheduler (N_SRC=4, DW=32).
// The bench plays the sources: each holds a sample until acked, then either
// drops it, re-offers the same sample, or offers a fresh random one. A
// transaction-level model (round-robin search, integer sum with clamping)
// predicts acks, written data and grant index.
module tb_audio_out_scheduler;

    localparam int N  = 4;
    localparam int DW = 32;

    logic       CLOCK_50;
    logic       reset_n;
    logic       mix_mode;
    logic       mute;
    logic [2:0] grant_idx;
    logic       busy;

    audio_out_scheduler_if #(.N_SRC(N), .DW(DW)) bus ();

    audio_out_scheduler #(.N_SRC(N), .DW(DW)) dut (
        .CLOCK_50  (CLOCK_50),
        .reset_n   (reset_n),
        .bus       (bus),
        .mix_mode  (mix_mode),
        .mute      (mute),
        .grant_idx (grant_idx),
        .busy      (busy)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    // source state and model state
    logic [N-1:0]          sv;
    logic signed [DW-1:0]  sl [N];
    logic signed [DW-1:0]  sr [N];
    logic                  mix_s, mute_s;
    int                    ptr_m, grant_m;
    int                    errors, checks;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        bus.src_valid = sv;
        for (int i = 0; i < N; i++) begin
            bus.src_left [i*DW +: DW] = sl[i];
            bus.src_right[i*DW +: DW] = sr[i];
        end
        mix_mode = mix_s;
        mute     = mute_s;
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    function automatic int rr_win(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic logic [DW-1:0] mix_ch(input bit right);
        longint     s;
        longint     hi;
        longint     lo;
        logic [63:0] t;
        s  = 0;
        hi = (longint'(1) <<< (DW - 1)) - 1;
        lo = -(longint'(1) <<< (DW - 1));
        for (int i = 0; i < N; i++)
            if (sv[i]) s += right ? longint'(sr[i]) : longint'(sl[i]);
        if (s > hi) s = hi;
        if (s < lo) s = lo;
        t = s;
        return t[DW-1:0];
    endfunction

    // refill: 0 = acked source goes idle, 1 = re-offers same sample, 2 = random
    task automatic txn(input string tag, input int stall, input int refill);
        logic [N-1:0]  ack_exp;
        logic [DW-1:0] le, re;
        int            w;
        string         t;
        drive();
        bus.audio_out_allowed = (stall == 0);
        w = rr_win(sv, ptr_m);
        ack_exp = '0;
        if (mix_s) ack_exp = sv;
        else if (w >= 0) ack_exp[w] = 1'b1;
        if (mute_s) begin
            le = '0; re = '0;
        end else if (mix_s) begin
            le = mix_ch(1'b0); re = mix_ch(1'b1);
        end else begin
            le = sl[w]; re = sr[w];
        end
        // IDLE cycle
        @(negedge CLOCK_50);
        chk({tag, "/idle_ready"}, 64'(bus.src_ready), 64'(0));
        chk({tag, "/idle_busy"}, 64'(busy), 64'(0));
        // LOAD cycle: ack
        @(negedge CLOCK_50);
        chk({tag, "/ack"}, 64'(bus.src_ready), 64'(ack_exp));
        chk({tag, "/load_busy"}, 64'(busy), 64'(1));
        step();
        if (!mix_s) begin
            grant_m = w;
            ptr_m   = (w + 1) % N;
        end
        for (int i = 0; i < N; i++) begin
            if (ack_exp[i]) begin
                if (refill == 0) sv[i] = 1'b0;
                else if (refill == 2) begin
                    sv[i] = 1'($urandom_range(0, 1));
                    sl[i] = $urandom;
                    sr[i] = $urandom;
                end
            end else if (refill == 2 && !sv[i] && $urandom_range(0, 3) == 0) begin
                sv[i] = 1'b1;
                sl[i] = $urandom;
                sr[i] = $urandom;
            end
        end
        drive();
        if (refill == 2) begin
            // mode inputs wiggling mid-transaction must not matter
            mix_mode = 1'($urandom_range(0, 1));
            mute     = 1'($urandom_range(0, 1));
        end
        for (int s = 0; s < stall; s++) begin
            @(negedge CLOCK_50);
            t = $sformatf("%s/stall%0d", tag, s);
            chk({t, "_write"}, 64'(bus.write_audio_out), 64'(0));
            chk({t, "_left"}, 64'(bus.left_channel_audio_out), 64'(le));
            chk({t, "_right"}, 64'(bus.right_channel_audio_out), 64'(re));
            chk({t, "_ready"}, 64'(bus.src_ready), 64'(0));
            step();
        end
        bus.audio_out_allowed = 1'b1;
        @(negedge CLOCK_50);
        chk({tag, "/strobe"}, 64'(bus.write_audio_out), 64'(1));
        chk({tag, "/left"}, 64'(bus.left_channel_audio_out), 64'(le));
        chk({tag, "/right"}, 64'(bus.right_channel_audio_out), 64'(re));
        chk({tag, "/grant"}, 64'(grant_idx), 64'(grant_m));
        chk({tag, "/write_ready"}, 64'(bus.src_ready), 64'(0));
        $display("txn %s: valid_ack=%b left=%h right=%h grant=%0d stall=%0d",
                 tag, ack_exp, le, re, grant_m, stall);
        step();
    endtask

    task automatic clear_src();
        sv = '0;
        for (int i = 0; i < N; i++) begin
            sl[i] = '0;
            sr[i] = '0;
        end
    endtask

    initial begin
        errors = 0; checks = 0;
        ptr_m = 0; grant_m = 0;
        mix_s = 1'b0; mute_s = 1'b0;
        clear_src();
        reset_n = 1'b0;
        bus.audio_out_allowed = 1'b0;
        drive();

        // reset state
        repeat (2) @(posedge CLOCK_50);
        #1;
        chk("reset/write", 64'(bus.write_audio_out), 64'(0));
        chk("reset/left", 64'(bus.left_channel_audio_out), 64'(0));
        chk("reset/right", 64'(bus.right_channel_audio_out), 64'(0));
        chk("reset/ready", 64'(bus.src_ready), 64'(0));
        chk("reset/grant", 64'(grant_idx), 64'(0));
        chk("reset/busy", 64'(busy), 64'(0));
        @(negedge CLOCK_50);
        reset_n = 1'b1;
        step();

        // round-robin fairness: all four sources always valid
        for (int i = 0; i < N; i++) begin
            sv[i] = 1'b1;
            sl[i] = DW'(i + 1);
            sr[i] = DW'(10 * (i + 1));
        end
        for (int k = 0; k < 5; k++) txn($sformatf("rr%0d", k), 0, 1);

        // backpressure: single source, FIFO full for 10 cycles
        clear_src();
        sv[0] = 1'b1; sl[0] = 32'h1234_5678; sr[0] = 32'hCAFE_0001;
        txn("bp", 10, 0);

        // saturating mix
        clear_src();
        mix_s = 1'b1;
        sv[0] = 1'b1; sl[0] = 32'h7000_0000; sr[0] = -32'sh7000_0000;
        sv[1] = 1'b1; sl[1] = 32'h7000_0000; sr[1] = -32'sh7000_0000;
        txn("mixsat", 0, 0);
        mix_s = 1'b0;

        // mute in round-robin mode: acked, zeros written, pointer moves on
        clear_src();
        mute_s = 1'b1;
        sv[2] = 1'b1; sl[2] = 32'h0098_9680; sr[2] = 32'h0098_9680;
        txn("mute", 0, 0);
        mute_s = 1'b0;
        // pointer now 3: source 3 beats source 0
        clear_src();
        sv[0] = 1'b1; sl[0] = 32'h0000_0A00; sr[0] = 32'h0000_0B00;
        sv[3] = 1'b1; sl[3] = 32'h0000_0A03; sr[3] = 32'h0000_0B03;
        txn("ptr3", 0, 0);
        txn("ptr3b", 0, 0);

        // sparse with wrap: pointer to 2, then only sources 1 and 3
        clear_src();
        sv[1] = 1'b1; sl[1] = 32'h0000_1111; sr[1] = 32'hFFFF_1111;
        txn("toptr2", 0, 0);
        sv[1] = 1'b1;
        sv[3] = 1'b1; sl[3] = 32'h0000_3333; sr[3] = 32'hFFFF_3333;
        for (int k = 0; k < 3; k++) txn($sformatf("sparse%0d", k), 1, 1);

        // source withdraws after IDLE saw it: no ack, no write
        clear_src();
        sv[0] = 1'b1; sl[0] = 32'h0BAD_0BAD;
        bus.audio_out_allowed = 1'b1;
        drive();
        step();
        sv = '0;
        drive();
        @(negedge CLOCK_50);
        chk("withdraw/ready", 64'(bus.src_ready), 64'(0));
        chk("withdraw/busy", 64'(busy), 64'(1));
        step();
        @(negedge CLOCK_50);
        chk("withdraw/idle", 64'(busy), 64'(0));
        chk("withdraw/write", 64'(bus.write_audio_out), 64'(0));
        $display("txn withdraw: no ack, no write");
        step();

        // randomized traffic
        for (int k = 0; k < 40; k++) begin
            mix_s  = 1'($urandom_range(0, 1));
            mute_s = ($urandom_range(0, 4) == 0);
            if (sv == '0) begin
                int j;
                j = $urandom_range(0, N - 1);
                sv[j] = 1'b1;
                sl[j] = $urandom;
                sr[j] = $urandom;
            end
            txn($sformatf("rand%0d", k), $urandom_range(0, 3), 2);
        end

        // asynchronous reset in WRITE
        clear_src();
        mix_s = 1'b0; mute_s = 1'b0;
        sv[1] = 1'b1; sl[1] = 32'h5555_AAAA; sr[1] = 32'hAAAA_5555;
        bus.audio_out_allowed = 1'b0;
        drive();
        step();
        step();
        sv = '0;
        drive();
        #3;
        chk("rst/pre_busy", 64'(busy), 64'(1));
        bus.audio_out_allowed = 1'b1;
        reset_n = 1'b0;
        #1;
        chk("rst/write", 64'(bus.write_audio_out), 64'(0));
        chk("rst/left", 64'(bus.left_channel_audio_out), 64'(0));
        chk("rst/right", 64'(bus.right_channel_audio_out), 64'(0));
        chk("rst/busy", 64'(busy), 64'(0));
        chk("rst/grant", 64'(grant_idx), 64'(0));
        ptr_m = 0; grant_m = 0;
        @(negedge CLOCK_50);
        reset_n = 1'b1;
        @(negedge CLOCK_50);
        chk("rst/after_write", 64'(bus.write_audio_out), 64'(0));
        chk("rst/after_busy", 64'(busy), 64'(0));
        $display("txn async_reset: pending sample discarded");
        step();

        // after reset the pointer starts at 0 again
        sv[0] = 1'b1; sl[0] = 32'h0000_00F0; sr[0] = 32'h0000_00F1;
        sv[2] = 1'b1; sl[2] = 32'h0000_00F2; sr[2] = 32'h0000_00F3;
        txn("post_rst", 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
